hw2_alu_issue: RTL and testbench
================================

Name: hw2_alu_issue

Overview:
- Issue and collect stage wrapped around HW2_alu.
- Accepts {inst, A, B} commands from a host over valid/ready and drives the ALU operand and instruction inputs.
- Tracks the ALU's fixed pipeline latency with a valid/tag shift register, then captures each result into an in-order response FIFO.
- Credit-based backpressure guarantees no result is ever dropped.

Parameters:
- ALU_LAT, 2: cycles from operands present on alu_*_o to result valid on alu_data_i.
- DEPTH, 4: response FIFO entries; power of 2, must be ≥ 2.

Ports:
- clk_p_i  in  1  clock, rising edge.
- reset_n_i  in  1  synchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command ready.
- cmd_inst_i  in  3  instruction: 000 add, 001 B-A, 010 mul, 011 and, 100 xor, 101 abs(A), 110 (B-A)<<2, 111 illegal.
- cmd_a_i  in  8  operand A.
- cmd_b_i  in  8  operand B.
- alu_a_o  out  8  to ALU data_a_i.
- alu_b_o  out  8  to ALU data_b_i.
- alu_inst_o  out  3  to ALU inst_i.
- alu_data_i  in  16  from ALU data_o.
- rsp_valid_o  out  1  response valid (FIFO not empty).
- rsp_ready_i  in  1  response ready.
- rsp_data_o  out  16  result at FIFO head.
- rsp_inst_o  out  3  instruction tag at FIFO head.
- illegal_o  out  1  one-cycle pulse when an inst=111 command is accepted.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (reset_n_i sampled on rising clk_p_i).
- While reset_n_i=0 at an edge:
  - alu_a_o, alu_b_o, alu_inst_o, rsp_data_o, rsp_inst_o = 0.
  - rsp_valid_o = 0, illegal_o = 0.
  - Valid pipe, FIFO pointers and count cleared.
  - cmd_ready_o = 1 from the first cycle after release.
- Reset mid-operation discards all in-flight and buffered results. No stale result may appear afterwards.
- Accept: cmd_valid_i & cmd_ready_o at an edge.
- Legal inst (≠111):
  - alu_a_o/alu_b_o/alu_inst_o load the command at that edge.
  - vpipe[0] and tag[0] are set for the following cycle N.
  - If nothing is accepted, alu_*_o hold their value and vpipe[0]=0.
- Illegal inst (111):
  - Command is consumed; alu_*_o hold their value and vpipe[0]=0.
  - illegal_o=1 for exactly the next cycle. No response is ever produced.
- Valid pipe: vpipe/tag are ALU_LAT+1 stages, shifted every edge. Stage k is high in cycle N+k.
- Capture: in a cycle with vpipe[ALU_LAT]=1, {tag[ALU_LAT], alu_data_i} is written to the FIFO at the closing edge.
  - With ALU_LAT=2, accept at edge E gives capture at edge E+3 and rsp_valid_o high from the cycle after E+3.
- FIFO:
  - Show-ahead: rsp_data_o/rsp_inst_o reflect the head whenever rsp_valid_o=1.
  - Pop on rsp_valid_o & rsp_ready_i.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Push into an empty FIFO is visible the next cycle; there is no same-cycle bypass.
- Credit (ready):
  - inflight = popcount(vpipe); pop = rsp_valid_o & rsp_ready_i.
  - cmd_ready_o = (count + inflight − pop) < DEPTH.
  - cmd_ready_o is combinational from registered state plus rsp_ready_i. It must not depend on cmd_valid_i.
  - Guarantees a push never finds the FIFO full. Assertion: push & full never true.
- Throughput: 1 command/cycle sustained when rsp_ready_i=1 (ALU_LAT=2, DEPTH=4: inflight 3, count 1).
- Ordering: responses leave strictly in accept order; illegal commands are skipped.
- Widths: results are passed through unmodified, 16 bits. No arithmetic in this block.

Test Plan:
- Reset: hold reset_n_i=0 for 2 edges with cmd_valid_i=1 → all outputs 0; cmd_ready_o=1 after release; no response appears.
- Single add: A=200, B=100, inst=000 accepted at edge E → alu_a_o=200, alu_b_o=100 from E; rsp_valid_o rises after E+3 with rsp_data_o=16'd300, rsp_inst_o=000; pop clears it.
- Backpressure: rsp_ready_i=0, 6 sub commands, first A=1, B=0 → exactly 4 accepted before cmd_ready_o=0; set rsp_ready_i=1 → 4 results in order, first 16'hFFFF; remaining 2 accepted afterwards.
- Illegal: inst=111 between two xor commands (A=8'hF0, B=8'h0F) → illegal_o pulses once; exactly 2 responses of 16'h00FF, tags 100.
- Throughput: 256 back-to-back mul commands (A=B=255 last), rsp_ready_i=1 → cmd_ready_o never drops; 256 responses in order; last = 16'hFE01.
- Reset mid-op: 3 commands in flight plus 1 buffered; reset_n_i=0 for one edge → rsp_valid_o=0 next cycle and stays 0 for ALU_LAT+2 cycles.

Source files
------------

// File: rtl/hw2_alu_issue.sv
// Issue/collect stage around HW2_alu: drives ALU operands from a valid/ready
// command port, tracks the fixed ALU latency with a valid/tag shift register
// and captures results into an in-order show-ahead response FIFO. Command
// acceptance is credit-gated so a capture never finds the FIFO full.
module hw2_alu_issue #(
  parameter int ALU_LAT = 2,  // operands on alu_*_o -> result on alu_data_i
  parameter int DEPTH   = 4   // response FIFO entries, power of 2, >= 2
) (
  input  logic        clk_p_i,
  input  logic        reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_inst_i,
  input  logic [7:0]  cmd_a_i,
  input  logic [7:0]  cmd_b_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_inst_o,
  input  logic [15:0] alu_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_data_o,
  output logic [2:0]  rsp_inst_o,
  output logic        illegal_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(ALU_LAT + 2);
  localparam logic [2:0] INST_ILLEGAL = 3'b111;

  typedef struct packed {
    logic [2:0]  inst;
    logic [15:0] data;
  } rsp_t;

  logic [ALU_LAT:0]      vld_pipe;
  logic [ALU_LAT:0][2:0] tag_pipe;
  rsp_t                  mem [DEPTH];
  rsp_t                  head;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [IW-1:0]         inflight;
  logic                  accept, legal, push, pop, full;

  assign accept = cmd_valid_i & cmd_ready_o;
  assign legal  = accept & (cmd_inst_i != INST_ILLEGAL);
  assign push   = vld_pipe[ALU_LAT];
  assign full   = (count == (AW+1)'(DEPTH));
  assign pop    = rsp_valid_o & rsp_ready_i;

  // Results in flight inside the ALU: every set bit of the valid pipe
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= ALU_LAT; k++)
      inflight = inflight + IW'(vld_pipe[k]);
  end

  // Credit: reserve a FIFO slot for every in-flight result; a same-cycle pop
  // frees one, so sustained 1/cycle works with a small FIFO
  assign cmd_ready_o = (32'(count) + 32'(inflight) - 32'(pop)) < 32'(DEPTH);

  // Issue: load ALU operands on legal accept, shift valid/tag, flag illegal
  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      alu_inst_o <= '0;
      illegal_o  <= 1'b0;
      vld_pipe   <= '0;
      tag_pipe   <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[ALU_LAT-1:0], legal};
      tag_pipe  <= {tag_pipe[ALU_LAT-1:0], cmd_inst_i};
      illegal_o <= accept & (cmd_inst_i == INST_ILLEGAL);
      if (legal) begin
        alu_a_o    <= cmd_a_i;
        alu_b_o    <= cmd_b_i;
        alu_inst_o <= cmd_inst_i;
      end
    end
  end

  // FIFO storage; contents need no reset since pointers/count gate visibility
  always_ff @(posedge clk_p_i) begin
    if (reset_n_i && push)
      mem[wr_ptr] <= '{inst: tag_pipe[ALU_LAT], data: alu_data_i};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk_p_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Show-ahead head; zeroed while empty so no stale entry is ever visible
  assign head        = mem[rd_ptr];
  assign rsp_valid_o = (count != '0);
  assign rsp_data_o  = rsp_valid_o ? head.data : '0;
  assign rsp_inst_o  = rsp_valid_o ? head.inst : '0;

  // The credit scheme must make overflow impossible
  assert property (@(posedge clk_p_i) disable iff (!reset_n_i) !(push && full));

endmodule

// File: tb/tb_hw2_alu_issue.sv
// Bench for hw2_alu_issue: behavioural 2-cycle ALU model, scoreboard queue
// filled on accepted commands and drained on popped responses.
module tb_hw2_alu_issue;

  localparam int ALU_LAT = 2;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_inst;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_inst;
  logic [15:0] alu_data;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_inst;
  logic        illegal;

  int n_cmp = 0, n_err = 0;
  int n_rsp = 0, ill_cnt = 0;
  logic [15:0] last_data;
  logic [2:0]  last_inst;
  logic [18:0] q [$];

  always #5 clk = ~clk;

  hw2_alu_issue #(.ALU_LAT(ALU_LAT), .DEPTH(DEPTH)) dut (
    .clk_p_i(clk), .reset_n_i(reset_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_inst_i(cmd_inst), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_inst_o(alu_inst),
    .alu_data_i(alu_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_inst_o(rsp_inst),
    .illegal_o(illegal)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] i, input logic [7:0] a, input logic [7:0] b);
    case (i)
      3'd0:    alu_f = {8'd0, a} + {8'd0, b};
      3'd1:    alu_f = {8'd0, b} - {8'd0, a};
      3'd2:    alu_f = 16'(a) * 16'(b);
      3'd3:    alu_f = {8'd0, a & b};
      3'd4:    alu_f = {8'd0, a ^ b};
      3'd5:    alu_f = {8'd0, a[7] ? (~a + 8'd1) : a};
      3'd6:    alu_f = ({8'd0, b} - {8'd0, a}) << 2;
      default: alu_f = 16'd0;
    endcase
  endfunction

  // ALU model: result of operands seen in cycle N is on alu_data in N+2
  logic [15:0] s1, s2;
  always @(posedge clk) begin
    s1 <= alu_f(alu_inst, alu_a, alu_b);
    s2 <= s1;
  end
  assign alu_data = s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor at negedge: pops/compares responses, pushes expectations on accept
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      if (illegal) ill_cnt++;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("rsp_unexpected", q.size(), 1);
        else begin
          logic [18:0] e;
          e = q.pop_front();
          chk("rsp_data", rsp_data, e[15:0]);
          chk("rsp_inst", rsp_inst, e[18:16]);
          last_data = rsp_data;
          last_inst = rsp_inst;
          n_rsp++;
        end
      end
      if (cmd_valid && cmd_ready && cmd_inst != 3'b111)
        q.push_back({cmd_inst, alu_f(cmd_inst, cmd_a, cmd_b)});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [2:0] i, input logic [7:0] a, input logic [7:0] b);
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_inst = i; cmd_a = a; cmd_b = b;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (q.size() != 0 || rsp_valid); t++) begin
      @(posedge clk); #1;
    end
    chk("drain_q", q.size(), 0);
  endtask

  initial begin
    int acc, drops, base_rsp, base_ill;
    reset_n = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_inst = 3'd0; cmd_a = 8'd1; cmd_b = 8'd2;

    // Reset with valid asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_inst", alu_inst, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_inst", rsp_inst, 0);
    chk("rst_illegal", illegal, 0);
    reset_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_no_rsp_cnt", n_rsp, 0);
    @(posedge clk); #1;

    // Single add: latency and show-ahead
    rsp_ready = 1'b0;
    send(3'd0, 8'd200, 8'd100);
    chk("add_alu_a", alu_a, 200);
    chk("add_alu_b", alu_b, 100);
    chk("add_alu_inst", alu_inst, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("add_early_vld", rsp_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("add_vld", rsp_valid, 1);
    chk("add_data", rsp_data, 16'd300);
    chk("add_inst", rsp_inst, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("add_popped", rsp_valid, 0);
    @(posedge clk); #1;

    // Backpressure: credit limits accepts to DEPTH
    rsp_ready = 1'b0; acc = 0; base_rsp = n_rsp;
    cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_inst = 3'd1; cmd_a = 8'(i + 1); cmd_b = 8'(i * 3);
      @(negedge clk);
      if (!cmd_ready) break;
      @(posedge clk); #1;
      acc++;
    end
    repeat (6) @(negedge clk);
    chk("bp_accepted", acc, DEPTH);
    chk("bp_ready_low", cmd_ready, 0);
    chk("bp_head", rsp_data, 16'hFFFF);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = acc; i < 6; i++) send(3'd1, 8'(i + 1), 8'(i * 3));
    drain();
    chk("bp_rsp_cnt", n_rsp - base_rsp, 6);

    // Illegal between two xors
    base_rsp = n_rsp; base_ill = ill_cnt;
    send(3'd4, 8'hF0, 8'h0F);
    send(3'd7, 8'h12, 8'h34);
    send(3'd4, 8'hF0, 8'h0F);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("ill_pulses", ill_cnt - base_ill, 1);
    chk("ill_rsp_cnt", n_rsp - base_rsp, 2);
    chk("ill_last_data", last_data, 16'h00FF);
    chk("ill_last_inst", last_inst, 3'b100);

    // Throughput: 256 back-to-back muls
    base_rsp = n_rsp; drops = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cmd_inst = 3'd2;
      cmd_a = 8'(i);
      cmd_b = (i == 255) ? 8'd255 : 8'(i * 3 + 7);
      @(negedge clk);
      if (!cmd_ready) drops++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    drain();
    chk("tp_drops", drops, 0);
    chk("tp_rsp_cnt", n_rsp - base_rsp, 256);
    chk("tp_last", last_data, 16'hFE01);

    // Reset mid-operation: 3 in flight + 1 buffered are discarded
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd0, 8'(10 + i), 8'd20);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < ALU_LAT + 2; k++) begin
      @(negedge clk); chk("mid_rsp_vld", rsp_valid, 0);
    end
    chk("mid_q", q.size(), 0);
    @(posedge clk); #1;
    chk("mid_ready", cmd_ready, 1);
    base_rsp = n_rsp;
    send(3'd5, 8'hFB, 8'd0);
    drain();
    chk("mid_resume_cnt", n_rsp - base_rsp, 1);
    chk("mid_resume_abs", last_data, 16'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
